// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive sampler: FSM encoding, default
// oversampling/parity settings and the 3-sample majority helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam bit          PARITY_EN_DEFAULT  = 1'b1;
  localparam bit          PARITY_ODD_DEFAULT = 1'b0;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector
// whose history flop advances only on i_en, so edges are seen at tick rate.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_rx,
  output logic o_rx,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      if (i_en) r_prev <= r_sync;
    end
  end

  assign o_rx   = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: majority-votes three mid-bit samples per bit,
// checks optional parity and the stop bit, and parks in BREAK on a low stop.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter bit          PARITY_EN  = PARITY_EN_DEFAULT,
  parameter bit          PARITY_ODD = PARITY_ODD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       Rx,
  output logic [8:0] frame,
  output logic       frame_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       busy
);

  localparam int unsigned CW = (OVERSAMPLE > 4) ? $clog2(OVERSAMPLE) : 2;
  localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] C_S2   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

  logic w_rx;
  logic w_fall;

  rx_sync u_rx_sync (
    .clk    (clk),
    .rst    (rst),
    .i_en   (baud_tick),
    .i_rx   (Rx),
    .o_rx   (w_rx),
    .o_fall (w_fall)
  );

  rx_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [1:0]    r_v, w_v_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_par, w_par_nxt;
  logic [8:0]    r_frame, w_frame_nxt;
  logic          r_perr, w_perr_nxt;
  logic          r_fv, w_fv_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic          r_busy;
  logic          w_vote;
  logic          w_vote_pt;

  // The third sample is taken live at the vote point rather than stored.
  assign w_vote    = maj3(r_v[0], r_v[1], w_rx);
  assign w_vote_pt = (r_cnt == C_S2);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_v_nxt     = r_v;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_frame_nxt = r_frame;
    w_perr_nxt  = r_perr;
    w_fv_nxt    = 1'b0;
    w_ferr_nxt  = 1'b0;

    if (baud_tick) begin
      w_cnt_nxt = (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
      if (r_cnt == C_S0) w_v_nxt[0] = w_rx;
      if (r_cnt == C_S1) w_v_nxt[1] = w_rx;

      unique case (r_state)
        StIdle: begin
          w_cnt_nxt = '0;
          w_bit_nxt = '0;
          if (w_fall) w_state_nxt = StStart;
        end
        StStart: begin
          if (w_vote_pt && w_vote) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_LAST) begin
            w_state_nxt = StData;
          end
        end
        StData: begin
          if (w_vote_pt) w_shift_nxt = {w_vote, r_shift[7:1]};
          if (r_cnt == C_LAST) begin
            w_bit_nxt = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nxt = PARITY_EN ? StParity : StStop;
          end
        end
        StParity: begin
          if (w_vote_pt) w_par_nxt = w_vote;
          if (r_cnt == C_LAST) w_state_nxt = StStop;
        end
        StStop: begin
          if (w_vote_pt) begin
            w_cnt_nxt = '0;
            if (w_vote) begin
              w_fv_nxt    = 1'b1;
              w_frame_nxt = {(PARITY_EN ? r_par : 1'b0), r_shift};
              w_perr_nxt  = PARITY_EN ? (^r_shift ^ r_par ^ PARITY_ODD) : 1'b0;
              w_state_nxt = w_fall ? StStart : StIdle;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = StBreak;
            end
          end
        end
        StBreak: begin
          w_cnt_nxt = '0;
          if (w_rx) w_state_nxt = StIdle;
        end
        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_v     <= 2'b11;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_frame <= '0;
      r_perr  <= 1'b0;
      r_fv    <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_v     <= w_v_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_frame <= w_frame_nxt;
      r_perr  <= w_perr_nxt;
      r_fv    <= w_fv_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != StIdle);
    end
  end

  assign frame       = r_frame;
  assign frame_valid = r_fv;
  assign parity_err  = r_perr;
  assign framing_err = r_ferr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: sends hand-built frames at 16 ticks per
// bit (one baud_tick every 4 clk) and compares outputs with hand-computed values.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       Rx = 1'b1;
  logic [8:0] frame;
  logic       frame_valid;
  logic       parity_err;
  logic       framing_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] fv_q[$];
  logic       perr_q[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;

  uart_rx_sampler #(
    .OVERSAMPLE (16),
    .PARITY_EN  (1'b1),
    .PARITY_ODD (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .Rx          (Rx),
    .frame       (frame),
    .frame_valid (frame_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_q.push_back(frame);
      perr_q.push_back(parity_err);
    end
    if (framing_err) ferr_cnt++;
    if (frame_valid && framing_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns on the clock edge at which the DUT samples the n-th tick.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic set_bit(input logic b);
    Rx = b;
    wait_ticks(16);
    #1;
  endtask

  // Start, 8 data bits LSB first and the parity bit; caller drives the stop.
  task automatic send_bits(input logic [7:0] data, input logic par);
    set_bit(1'b0);
    for (int i = 0; i < 8; i++) set_bit(data[i]);
    set_bit(par);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    send_bits(data, par);
    set_bit(stop);
    Rx = 1'b1;
  endtask

  task automatic align();
    wait_ticks(1);
    #1;
  endtask

  initial begin
    int n0;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int f0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame", frame, 9'h000);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", framing_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    wait_ticks(4);
    #1;

    // 0xA5, even parity 0, good stop; also checks frame_valid latency/width.
    n0 = fv_q.size();
    send_bits(8'hA5, 1'b0);
    Rx = 1'b1;
    wait_ticks(11);
    #1;
    check("a5_fv_latency", frame_valid, 1'b1);
    @(posedge clk);
    #1;
    check("a5_fv_width", frame_valid, 1'b0);
    check("a5_frame", frame, 9'h0A5);
    check("a5_perr", parity_err, 1'b0);
    check("a5_busy", busy, 1'b0);
    wait_ticks(5);
    #1;
    check("a5_count", fv_q.size() - n0, 1);

    // 0x3C with parity bit 1 in even mode -> parity error.
    align();
    n0 = fv_q.size();
    send_frame(8'h3C, 1'b1, 1'b1);
    check("3c_count", fv_q.size() - n0, 1);
    check("3c_frame", frame, 9'h13C);
    check("3c_perr", parity_err, 1'b1);

    // 0x55 with low stop held for 3 bit times -> framing error, BREAK.
    align();
    n0 = fv_q.size();
    f0 = ferr_cnt;
    send_bits(8'h55, 1'b0);
    Rx = 1'b0;
    wait_ticks(40);
    #1;
    check("brk_busy_low", busy, 1'b1);
    check("brk_ferr_count", ferr_cnt - f0, 1);
    wait_ticks(8);
    #1;
    Rx = 1'b1;
    wait_ticks(3);
    #1;
    check("brk_busy_release", busy, 1'b0);
    check("brk_fv_count", fv_q.size() - n0, 0);
    check("brk_frame_held", frame, 9'h13C);
    check("brk_perr_held", parity_err, 1'b1);

    // 4-tick glitch on idle line -> START then back to IDLE, no outputs.
    align();
    n0 = fv_q.size();
    f0 = ferr_cnt;
    Rx = 1'b0;
    wait_ticks(2);
    #1;
    check("glitch_busy_start", busy, 1'b1);
    wait_ticks(2);
    #1;
    Rx = 1'b1;
    wait_ticks(12);
    #1;
    check("glitch_busy_end", busy, 1'b0);
    check("glitch_fv_count", fv_q.size() - n0, 0);
    check("glitch_ferr_count", ferr_cnt - f0, 0);

    // Back-to-back 0x01 and 0xFE, both with even parity bit 1.
    wait_ticks(16);
    #1;
    n0 = fv_q.size();
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b1, 1'b1);
    check("b2b_count", fv_q.size() - n0, 2);
    if (fv_q.size() - n0 == 2) begin
      check("b2b_frame0", fv_q[n0], 9'h101);
      check("b2b_frame1", fv_q[n0+1], 9'h1FE);
      check("b2b_perr0", perr_q[n0], 1'b0);
      check("b2b_perr1", perr_q[n0+1], 1'b0);
    end

    // Reset in the middle of data bit 4, then a clean 0x81.
    wait_ticks(8);
    #1;
    n0 = fv_q.size();
    set_bit(1'b0);
    for (int i = 0; i < 4; i++) set_bit(1'b1);
    Rx = 1'b0;
    wait_ticks(8);
    #1;
    check("rstmid_busy_pre", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_frame", frame, 9'h000);
    Rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_ticks(20);
    #1;
    send_frame(8'h81, 1'b0, 1'b1);
    wait_ticks(4);
    #1;
    check("rstmid_count", fv_q.size() - n0, 1);
    check("rstmid_frame_81", frame, 9'h081);
    check("rstmid_perr", parity_err, 1'b0);

    check("fv_ferr_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
